// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and helpers for the systolic array feeder and collector
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    // Zero-vector cycles needed for the last partial sum to leave the bottom edge.
    function automatic int drain_cycles(input int rows, input int cols);
        return 2 * rows + cols - 2;
    endfunction

    // Bit offset of a lane inside a packed multi-lane bus; used for both pack and unpack.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - fixed-latency {valid, data} delay line, DEPTH+1 register stages
module sa_skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W:0] stage_q [DEPTH+1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i <= DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= {valid_i, data_i};
            for (int i = 1; i <= DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {valid_o, data_o} = stage_q[DEPTH];

endmodule

// File: rtl/sys_array_feeder.sv
// rtl/sys_array_feeder.sv - weight loader and skewed activation streamer; SA_FEEDER_PERF_EN adds perf counters
module sys_array_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NVEC_W     = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       reuse_w,
    input  logic [NVEC_W-1:0]          n_vec,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_data,
    output logic [ROWS-1:0]            param_load,
    output logic [COLS*DATA_WIDTH-1:0] param_data,
    output logic [ROWS*DATA_WIDTH-1:0] input_data,
    output logic [ROWS-1:0]            lane_valid,
    output logic                       busy,
    output logic                       done
`ifdef SA_FEEDER_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_job_cycles
`endif
);
    import sa_pkg::*;

    localparam int DRAIN_CYCLES = drain_cycles(ROWS, COLS);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    feeder_state_t                state_q, state_d;
    logic [NVEC_W-1:0]            remaining_q, remaining_d;
    logic [RW-1:0]                row_q, row_d;
    logic [DCW-1:0]               drain_q, drain_d;
    logic [ROWS-1:0]              param_load_q, param_load_d;
    logic [COLS*DATA_WIDTH-1:0]   param_data_q, param_data_d;
    logic                         a_fire;

    assign busy       = (state_q != IDLE);
    assign w_ready    = (state_q == LOAD);
    assign a_ready    = (state_q == STREAM) && (remaining_q != '0);
    assign a_fire     = a_ready && a_valid;
    assign param_load = param_load_q;
    assign param_data = param_data_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            row_q        <= '0;
            drain_q      <= '0;
            param_load_q <= '0;
            param_data_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            row_q        <= row_d;
            drain_q      <= drain_d;
            param_load_q <= param_load_d;
            param_data_q <= param_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        row_d        = row_q;
        drain_d      = drain_q;
        param_load_d = '0;
        param_data_d = param_data_q;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = n_vec;
                    row_d       = '0;
                    drain_d     = '0;
                    state_d     = reuse_w ? STREAM : LOAD;
                end
            end
            LOAD: begin
                if (w_valid) begin
                    param_load_d = ROWS'(1) << row_q;
                    param_data_d = w_data;
                    row_d        = row_q + 1'b1;
                    if (row_q == RW'(ROWS - 1)) begin
                        // An empty job finishes as soon as the weights are in.
                        if (remaining_q == '0) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
            end
            STREAM: begin
                if (remaining_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (a_valid) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == NVEC_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    done    = 1'b1;
                    drain_d = '0;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane r is delayed r extra cycles to form the diagonal wavefront.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;
        assign lane_in = a_fire ? a_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] : '0;

        sa_skew_line #(
            .W     (DATA_WIDTH),
            .DEPTH (r)
        ) u_skew (
            .clock   (clock),
            .reset_n (reset_n),
            .valid_i (a_fire),
            .data_i  (lane_in),
            .valid_o (lane_valid[r]),
            .data_o  (input_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

`ifdef SA_FEEDER_PERF_EN
    logic [31:0] stall_cnt_q, job_cycles_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            job_cycles_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_cnt_q  <= '0;
            job_cycles_q <= '0;
        end else begin
            if (busy) begin
                job_cycles_q <= job_cycles_q + 32'd1;
            end
            if (a_ready && !a_valid) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// tb/tb_sys_array_feeder.sv - directed self-checking bench for sys_array_feeder
module tb_sys_array_feeder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        reuse_w;
    logic [15:0] n_vec;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [3:0]  param_load;
    logic [31:0] param_data;
    logic [31:0] input_data;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        done;
`ifdef SA_FEEDER_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_job_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sys_array_feeder #(
        .DATA_WIDTH (8),
        .ROWS       (4),
        .COLS       (4),
        .NVEC_W     (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .reuse_w    (reuse_w),
        .n_vec      (n_vec),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .param_load (param_load),
        .param_data (param_data),
        .input_data (input_data),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
`ifdef SA_FEEDER_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_job_cycles (perf_job_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic rw, input logic [15:0] nv);
        start   = 1'b1;
        reuse_w = rw;
        n_vec   = nv;
        tick;
        start   = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            tick;
            k++;
        end
    endtask

    function automatic logic [31:0] wrow(input int r);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(16 * (r + 1) + c);
        return v;
    endfunction

    task automatic load_rows(input string tag);
        w_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            w_data = wrow(r);
            check($sformatf("%s_wready%0d", tag, r), 64'(w_ready), 64'd1);
            tick;
            check($sformatf("%s_pload%0d", tag, r), 64'(param_load), 64'(4'b0001 << r));
            check($sformatf("%s_pdata%0d", tag, r), 64'(param_data), 64'(wrow(r)));
        end
        w_valid = 1'b0;
        tick;
        check($sformatf("%s_pload_off", tag), 64'(param_load), 64'd0);
        check($sformatf("%s_wready_off", tag), 64'(w_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0]  vb [4];
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        int          k;
        int          bl;

        vb[0] = 8'h01; vb[1] = 8'hFE; vb[2] = 8'h03; vb[3] = 8'h80;
        reset_n = 1'b0; start = 1'b0; reuse_w = 1'b0; n_vec = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        tick; tick; tick;
        check("rst_outs", 64'({param_load, param_data, input_data, lane_valid}), 64'd0);
        check("rst_ctrl", 64'({busy, done, w_ready, a_ready}), 64'd0);
        reset_n = 1'b1;
        tick;

        // Job A: load 4 rows, 3 back-to-back vectors, measure drain.
        start_job(1'b0, 16'd3);
        check("a_busy", 64'(busy), 64'd1);
        load_rows("a");
        a_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            a_data = {4{8'(v + 1)}};
            check($sformatf("a_aready%0d", v), 64'(a_ready), 64'd1);
            tick;
        end
        a_valid = 1'b0;
        check("a_aready_drain", 64'(a_ready), 64'd0);
        wait_done(k);
        check("a_drain_len", 64'(k + 1), 64'd10);
        tick;
        check("a_idle", 64'(busy), 64'd0);

        // Job B: single vector skew.
        start_job(1'b1, 16'd1);
        check("b_aready", 64'(a_ready), 64'd1);
        a_valid = 1'b1;
        a_data  = {8'h80, 8'h03, 8'hFE, 8'h01};
        tick;
        a_valid = 1'b0;
        a_data  = '0;
        for (int d = 1; d <= 6; d++) begin
            exp_v = '0; exp_d = '0;
            for (int r = 0; r < 4; r++) begin
                if (d == r + 1) begin
                    exp_v[r] = 1'b1;
                    exp_d[r*8 +: 8] = vb[r];
                end
            end
            check($sformatf("b_valid_t%0d", d), 64'(lane_valid), 64'(exp_v));
            check($sformatf("b_data_t%0d", d), 64'(input_data), 64'(exp_d));
            tick;
        end
        wait_done(k);
        check("b_done", 64'(done), 64'd1);
        tick;

        // Job C: a_valid 1,0,1 gives one bubble per lane.
        start_job(1'b1, 16'd2);
        for (int d = 0; d <= 7; d++) begin
            a_valid = (d == 0 || d == 2);
            a_data  = (d == 0) ? 32'h44332211 : ((d == 2) ? 32'hA3A2A1A0 : 32'h0);
            check($sformatf("c_aready_t%0d", d), 64'(a_ready), (d <= 2) ? 64'd1 : 64'd0);
            exp_v = '0; exp_d = '0;
            for (int r = 0; r < 4; r++) begin
                if (d == r + 1) begin
                    exp_v[r] = 1'b1;
                    exp_d[r*8 +: 8] = 8'(8'h11 * (r + 1));
                end else if (d == r + 3) begin
                    exp_v[r] = 1'b1;
                    exp_d[r*8 +: 8] = 8'(8'hA0 + r);
                end
            end
            check($sformatf("c_valid_t%0d", d), 64'(lane_valid), 64'(exp_v));
            check($sformatf("c_data_t%0d", d), 64'(input_data), 64'(exp_d));
            tick;
        end
        a_valid = 1'b0;
        a_data  = '0;
        wait_done(k);
        check("c_done", 64'(done), 64'd1);
        tick;

        // Job D: reuse_w with zero vectors.
        start_job(1'b1, 16'd0);
        check("d_busy_done", 64'({busy, done}), 64'b11);
        check("d_quiet", 64'({param_load, lane_valid}), 64'd0);
        tick;
        check("d_after", 64'({busy, done, lane_valid}), 64'd0);

        // Job E: start held during STREAM is dropped.
        start_job(1'b1, 16'd2);
        start = 1'b1; reuse_w = 1'b0; n_vec = 16'd5;
        a_valid = 1'b1; a_data = 32'h01020304;
        tick;
        check("e_wready", 64'(w_ready), 64'd0);
        tick;
        start = 1'b0; a_valid = 1'b0;
        check("e_drain", 64'({busy, w_ready, a_ready}), 64'b100);
        wait_done(k);
        check("e_drain_len", 64'(k + 1), 64'd10);
        tick;
        check("e_idle", 64'(busy), 64'd0);

        // Job F: reset mid-LOAD, then a full reload.
        start_job(1'b0, 16'd1);
        w_valid = 1'b1; w_data = wrow(0);
        tick;
        check("f_pload0", 64'(param_load), 64'd1);
        reset_n = 1'b0;
        tick;
        check("f_rst_outs", 64'({param_load, param_data, input_data, lane_valid}), 64'd0);
        check("f_rst_ctrl", 64'({busy, done, w_ready, a_ready}), 64'd0);
        reset_n = 1'b1; w_valid = 1'b0;
        tick;
        start_job(1'b0, 16'd1);
        load_rows("f");
        a_valid = 1'b1; a_data = 32'h05060708;
        tick;
        a_valid = 1'b0;
        wait_done(k);
        check("f_drain_len", 64'(k + 1), 64'd10);
        tick;

`ifdef SA_FEEDER_PERF_EN
        // Job G: 3 vectors with 2 stalls.
        start_job(1'b1, 16'd3);
        bl = 0;
        for (int i = 0; i < 5; i++) begin
            a_valid = (i == 0 || i == 3 || i == 4);
            a_data  = 32'h0A0B0C0D;
            bl += int'(busy);
            tick;
        end
        a_valid = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            bl++;
            tick;
            k++;
        end
        check("g_busy_len", 64'(bl), 64'd15);
        check("g_stalls", 64'(perf_stall_cnt), 64'd2);
        check("g_job_cycles", 64'(perf_job_cycles), 64'(bl));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
